if_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC, issues requests to a variable-latency instruction memory over a req/ready handshake, and applies redirects from Execute.
- Honours StallF/StallD/FlushD from the hazard unit.
- Feeds InstrD/PCD/PCPlus4D to Decode, whose Rs1D/Rs2D go back to the hazard unit.

---
 rtl/if_stage.sv | 171 +++++++++++++++++
 tb/tb_if_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage plus IF/ID pipeline register.
// Owns the PC, fetches over a req/ready handshake, and applies Execute redirects.
module if_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            FetchBusyF
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [31:0]     hold_q, hold_d;
  logic [31:0]     instrd_q, instrd_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pcplus4d_q, pcplus4d_d;

  logic            redirect_s;
  logic [XLEN-1:0] target_sel_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic            deliver_s;
  logic            req_s;
  logic [31:0]     fetch_instr_s;

  // Fetch FSM next-state, PC/ReqAddr update and delivery decision.
  always_comb begin
    redirect_s    = (PCSrcE != 2'b00);
    target_sel_s  = (PCSrcE == 2'b10) ? ALUResultE : PCTargetE;
    target_s      = {target_sel_s[XLEN-1:2], 2'b00};
    pc_plus4_s    = pcf_q + XLEN'(4);
    state_d       = state_q;
    pcf_d         = pcf_q;
    req_addr_d    = req_addr_q;
    hold_d        = hold_q;
    deliver_s     = 1'b0;
    req_s         = 1'b0;
    fetch_instr_s = hold_q;
    case (state_q)
      S_REQ: begin
        req_s         = 1'b1;
        fetch_instr_s = imem_rdata;
        if (imem_ready) begin
          if (redirect_s) begin
            pcf_d      = target_s;
            req_addr_d = target_s;
          end else if (StallF) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            deliver_s  = 1'b1;
            pcf_d      = pc_plus4_s;
            req_addr_d = pc_plus4_s;
          end
        end else if (redirect_s) begin
          // The old request stays on the bus until the memory accepts it.
          pcf_d   = target_s;
          state_d = S_DRAIN;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_s) begin
          pcf_d      = target_s;
          req_addr_d = target_s;
          state_d    = S_REQ;
        end else if (StallF) begin
          state_d = S_HOLD;
        end else begin
          deliver_s  = 1'b1;
          pcf_d      = pc_plus4_s;
          req_addr_d = pc_plus4_s;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        req_s = 1'b1;
        if (redirect_s) begin
          pcf_d = target_s;
        end else begin
          pcf_d = pcf_q;
        end
        if (imem_ready) begin
          req_addr_d = redirect_s ? target_s : pcf_q;
          state_d    = S_REQ;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d    = S_REQ;
        pcf_d      = RESET_PC;
        req_addr_d = RESET_PC;
      end
    endcase
  end

  // IF/ID register next values: flush beats stall, stall beats delivery.
  always_comb begin
    instrd_d   = instrd_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    if (FlushD) begin
      instrd_d   = NOP;
      pcd_d      = '0;
      pcplus4d_d = '0;
    end else if (StallD) begin
      instrd_d   = instrd_q;
    end else if (deliver_s) begin
      instrd_d   = fetch_instr_s;
      pcd_d      = pcf_q;
      pcplus4d_d = pc_plus4_s;
    end else begin
      instrd_d   = NOP;
      pcd_d      = '0;
      pcplus4d_d = '0;
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pcf_q      <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_q     <= 32'h0000_0000;
      instrd_q   <= NOP;
      pcd_q      <= '0;
      pcplus4d_q <= '0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      req_addr_q <= req_addr_d;
      hold_q     <= hold_d;
      instrd_q   <= instrd_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
    end
  end

  assign imem_req   = req_s;
  assign imem_addr  = req_addr_q;
  assign FetchBusyF = !deliver_s;
  assign InstrD     = instrd_q;
  assign PCD        = pcd_q;
  assign PCPlus4D   = pcplus4d_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus hand-written reset sequences.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        StallF, StallD, FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        FetchBusyF;

  int n_checks = 0;
  int n_pass   = 0;
  logic saw_w20 = 1'b0;

  if_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FetchBusyF(FetchBusyF)
  );

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hAB00_0000 | a;
  endfunction

  // Memory returns an address-tagged word so each delivery is identifiable.
  assign imem_rdata = w(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (InstrD == w(32'd20)) saw_w20 = 1'b1;
  end

  typedef struct {
    logic        rst;
    logic        ready;
    logic        sf;
    logic        sd;
    logic        fd;
    logic [1:0]  pcsrc;
    logic [31:0] tgt;
    logic [31:0] alu;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic [31:0] e_instr;
    logic [31:0] e_pcd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic sf, input logic sd,
                     input logic fd, input logic [1:0] src, input logic [31:0] tgt,
                     input logic [31:0] alu, input logic e_req, input logic [31:0] e_addr,
                     input logic e_busy, input logic [31:0] e_instr, input logic [31:0] e_pcd);
    vec_t v;
    v.rst = r; v.ready = rdy; v.sf = sf; v.sd = sd; v.fd = fd; v.pcsrc = src;
    v.tgt = tgt; v.alu = alu; v.e_req = e_req; v.e_addr = e_addr; v.e_busy = e_busy;
    v.e_instr = e_instr; v.e_pcd = e_pcd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_d(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pcd);
    logic [31:0] e_pc4;
    e_pc4 = (e_instr == NOP && e_pcd == 32'd0) ? 32'd0 : e_pcd + 32'd4;
    check({tag, ".InstrD"}, InstrD, e_instr);
    check({tag, ".PCD"}, PCD, e_pcd);
    check({tag, ".PCPlus4D"}, PCPlus4D, e_pc4);
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 2'b00;
    PCTargetE = 32'd0; ALUResultE = 32'd0; imem_ready = 1'b1;

    //  rst rdy sf sd fd src tgt           alu          req addr          busy instrD              pcd
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h0,        0, NOP,                32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h4,        0, w(32'h0),           32'h0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h8,        1, w(32'h4),           32'h4);
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h8,        1, NOP,                32'h0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h8,        1, NOP,                32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h8,        0, NOP,                32'h0);
    add(0, 1, 1, 1, 0, 0, 32'h0,        32'h0,       1, 32'hC,        1, w(32'h8),           32'h8);
    add(0, 1, 1, 1, 0, 0, 32'h0,        32'h0,       0, 32'hC,        1, w(32'h8),           32'h8);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       0, 32'hC,        0, w(32'h8),           32'h8);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h10,       0, w(32'hC),           32'hC);
    add(0, 0, 0, 0, 1, 1, 32'h103,      32'h0,       1, 32'h14,       1, w(32'h10),          32'h10);
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h14,       1, NOP,                32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h14,       1, NOP,                32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h100,      0, NOP,                32'h0);
    add(0, 1, 1, 0, 1, 2, 32'h200,      32'h40,      1, 32'h104,      1, w(32'h100),         32'h100);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h40,       0, NOP,                32'h0);
    add(0, 0, 0, 0, 0, 1, 32'h80,       32'h0,       1, 32'h44,       1, w(32'h40),          32'h40);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h0,        1, NOP,                32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h0,        0, NOP,                32'h0);
    add(0, 1, 0, 1, 1, 0, 32'h0,        32'h0,       1, 32'h4,        0, w(32'h0),           32'h0);
    add(0, 1, 0, 0, 0, 3, 32'hFFFF_FFFE, 32'h500,    1, 32'h8,        1, NOP,                32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'hFFFF_FFFC, 0, NOP,               32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h0,        0, w(32'hFFFF_FFFC),   32'hFFFF_FFFC);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,       1, 32'h4,        0, w(32'h0),           32'h0);

    // Reset state while rst is held.
    @(negedge clk);
    @(negedge clk);
    check("rst.req", {31'd0, imem_req}, 32'd1);
    check("rst.addr", imem_addr, 32'd0);
    check_d("rst", NOP, 32'd0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; imem_ready = vecs[i].ready; StallF = vecs[i].sf;
      StallD = vecs[i].sd; FlushD = vecs[i].fd; PCSrcE = vecs[i].pcsrc;
      PCTargetE = vecs[i].tgt; ALUResultE = vecs[i].alu;
      @(negedge clk);
      check($sformatf("v%0d.req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      check($sformatf("v%0d.addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d.busy", i), {31'd0, FetchBusyF}, {31'd0, vecs[i].e_busy});
      check_d($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_pcd);
    end

    // Enter DRAIN on the pending fetch of 8, then reset asynchronously mid-cycle.
    @(posedge clk); #1;
    imem_ready = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h300;
    @(posedge clk); #1;
    PCSrcE = 2'b00;
    @(negedge clk);
    check("drain.addr", imem_addr, 32'h8);
    check("drain.busy", {31'd0, FetchBusyF}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst.addr", imem_addr, 32'h0);
    check_d("arst", NOP, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    check("post_rst.addr", imem_addr, 32'h0);
    check("post_rst.req", {31'd0, imem_req}, 32'd1);
    check_d("post_rst", NOP, 32'd0);
    @(negedge clk);
    check_d("post_rst2", w(32'h0), 32'd0);
    check("post_rst2.addr", imem_addr, 32'h4);

    check("never_w20", {31'd0, saw_w20}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
